// File: rtl/lab1_gate_checker_pkg.sv
// Shared definitions for the gate-block self-test stage: FSM state
// encoding, sweep size and the small arithmetic helper used by the checker.
package lab1_gate_checker_pkg;

  // Checker FSM states; the encodings are fixed so that other lab blocks
  // can decode them directly.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Number of (A,B) input vectors in one sweep.
  localparam int NUM_VEC = 4;

  // Width of the settle counter; covers the legal SETTLE_CYCLES range 1..15.
  localparam int CNT_W = 4;

  // Number of set bits in a 3-bit mismatch vector (0..3).
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    logic [1:0] sum;
    sum = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    return sum;
  endfunction

endpackage

// File: rtl/lab1_gate_golden.sv
// Golden reference for the gate lab: AND, OR and NOT of the current
// vector ({A,B} = vec), built only from two-input NAND primitives so the
// reference is constructed the same way as the block under test.
module lab1_gate_golden (
  input  logic [1:0] vec,
  output logic       expAND,
  output logic       expOR,
  output logic       expNOT
);

  logic nand_ab_s;
  logic not_a_s;
  logic not_b_s;

  // AND = NAND followed by a NAND wired as an inverter.
  nand u_nand_ab  (nand_ab_s, vec[1], vec[0]);
  nand u_and_out  (expAND, nand_ab_s, nand_ab_s);

  // OR = NAND of the two inverted inputs (De Morgan).
  nand u_inv_a    (not_a_s, vec[1], vec[1]);
  nand u_inv_b    (not_b_s, vec[0], vec[0]);
  nand u_or_out   (expOR, not_a_s, not_b_s);

  // NOT A = NAND with both inputs tied to A.
  nand u_not_out  (expNOT, vec[1], vec[1]);

endmodule

// File: rtl/lab1_gate_checker.sv
// Sequential self-test stage around the NAND-built AND/OR/NOT gate block.
// Drives the four (A,B) vectors in order, holds each for SETTLE_CYCLES,
// samples the three observed outputs for one cycle, compares them against
// the golden model and accumulates a per-vector failure mask plus a
// saturating count of mismatched output bits.
module lab1_gate_checker
  import lab1_gate_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             obsAND,
  input  logic             obsOR,
  input  logic             obsNOT,
  output logic             drvA,
  output logic             drvB,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       fail_mask,
  output logic [ERR_W-1:0] err_count
);

  // Last value of the settle counter before moving to SAMPLE.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  // Index of the final vector of a sweep.
  localparam logic [1:0]       LAST_VEC    = 2'(NUM_VEC - 1);
  // Saturation ceiling of the error accumulator.
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  state_e           state_r;
  logic [1:0]       vec_r;
  logic [CNT_W-1:0] cnt_r;
  logic             drv_a_r;
  logic             drv_b_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [3:0]       fail_mask_r;
  logic [ERR_W-1:0] err_count_r;

  logic             exp_and_s;
  logic             exp_or_s;
  logic             exp_not_s;
  logic [2:0]       mismatch_s;
  logic [1:0]       mism_cnt_s;
  logic [ERR_W+1:0] err_sum_s;
  logic [ERR_W-1:0] err_next_s;
  logic [3:0]       mask_next_s;
  logic [1:0]       vec_inc_s;

  // Golden expectations for the vector currently being driven.
  lab1_gate_golden u_golden (
    .vec    (vec_r),
    .expAND (exp_and_s),
    .expOR  (exp_or_s),
    .expNOT (exp_not_s)
  );

  // Compare observed outputs with the golden model and form the next
  // mask / error-count values; they are only committed in SAMPLE, so
  // anything seen on obs* while driving has no effect.
  always_comb begin
    mismatch_s  = {obsAND ^ exp_and_s, obsOR ^ exp_or_s, obsNOT ^ exp_not_s};
    mism_cnt_s  = popcount3(mismatch_s);
    err_sum_s   = {2'b00, err_count_r} + {{ERR_W{1'b0}}, mism_cnt_s};
    vec_inc_s   = vec_r + 2'd1;
    if (err_sum_s > {2'b00, ERR_MAX}) begin
      err_next_s = ERR_MAX;
    end else begin
      err_next_s = err_sum_s[ERR_W-1:0];
    end
    if (mism_cnt_s != 2'd0) begin
      mask_next_s = fail_mask_r | (4'b0001 << vec_r);
    end else begin
      mask_next_s = fail_mask_r;
    end
  end

  // Sweep FSM with settle counter, vector counter, result accumulation and
  // all externally visible outputs held in registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      vec_r       <= 2'd0;
      cnt_r       <= {CNT_W{1'b0}};
      drv_a_r     <= 1'b0;
      drv_b_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_mask_r <= 4'b0000;
      err_count_r <= {ERR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          // A new sweep discards any previous result; done drops here.
          if (start) begin
            state_r     <= ST_DRIVE;
            vec_r       <= 2'd0;
            cnt_r       <= {CNT_W{1'b0}};
            drv_a_r     <= 1'b0;
            drv_b_r     <= 1'b0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_mask_r <= 4'b0000;
            err_count_r <= {ERR_W{1'b0}};
          end
        end
        ST_DRIVE: begin
          // Hold the vector until the gate block has had time to settle.
          if (cnt_r == SETTLE_LAST) begin
            state_r <= ST_SAMPLE;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_SAMPLE: begin
          fail_mask_r <= mask_next_s;
          err_count_r <= err_next_s;
          if (vec_r == LAST_VEC) begin
            // Drive pins keep the last vector (1,1) while results are shown.
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (mask_next_s == 4'b0000);
          end else begin
            state_r <= ST_DRIVE;
            vec_r   <= vec_inc_s;
            cnt_r   <= {CNT_W{1'b0}};
            drv_a_r <= vec_inc_s[1];
            drv_b_r <= vec_inc_s[0];
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign drvA      = drv_a_r;
  assign drvB      = drv_b_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail_mask = fail_mask_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_lab1_gate_checker.sv
// Bench for lab1_gate_checker. Two checkers run side by side:
//   unit 0: SETTLE_CYCLES=1, ERR_W=4
//   unit 1: SETTLE_CYCLES=3, ERR_W=2
// Each unit watches a modelled gate block whose outputs can be corrupted
// per vector through a 12-bit flip table (bits [3k+2:3k] = {AND,OR,NOT}
// flips for {A,B}=k) and glitched on OR.
module tb_lab1_gate_checker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start     [2];
  logic [11:0] flip     [2];
  logic       glitch    [2];
  logic       drv_a     [2];
  logic       drv_b     [2];
  logic       busy      [2];
  logic       done      [2];
  logic       pass      [2];
  logic [3:0] fail_mask [2];
  logic       obs_and   [2];
  logic       obs_or    [2];
  logic       obs_not   [2];
  logic [3:0] err0;
  logic [1:0] err1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Gate block model: ideal AND/OR/NOT, then per-vector flips and OR glitch.
  function automatic logic [2:0] gate_obs(input logic a, input logic b,
                                          input logic [11:0] fl, input logic g);
    int k;
    logic [2:0] ideal;
    k = (a ? 2 : 0) + (b ? 1 : 0);
    ideal = {a & b, a | b, ~a};
    return ideal ^ fl[3*k +: 3] ^ {1'b0, g, 1'b0};
  endfunction

  assign {obs_and[0], obs_or[0], obs_not[0]} = gate_obs(drv_a[0], drv_b[0], flip[0], glitch[0]);
  assign {obs_and[1], obs_or[1], obs_not[1]} = gate_obs(drv_a[1], drv_b[1], flip[1], glitch[1]);

  lab1_gate_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]),
    .obsAND(obs_and[0]), .obsOR(obs_or[0]), .obsNOT(obs_not[0]),
    .drvA(drv_a[0]), .drvB(drv_b[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .fail_mask(fail_mask[0]), .err_count(err0)
  );

  lab1_gate_checker #(.SETTLE_CYCLES(3), .ERR_W(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]),
    .obsAND(obs_and[1]), .obsOR(obs_or[1]), .obsNOT(obs_not[1]),
    .drvA(drv_a[1]), .drvB(drv_b[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .fail_mask(fail_mask[1]), .err_count(err1)
  );

  function automatic int settle_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic int errmax_of(input int u);
    return (u == 0) ? 15 : 3;
  endfunction

  function automatic int err_of(input int u);
    return (u == 0) ? int'(err0) : int'(err1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: a vector fails if any of its outputs is flipped; the error
  // count is the total number of flipped outputs, clipped at the maximum.
  task automatic model(input logic [11:0] fl, input int emax,
                       output int mask, output int err);
    logic [2:0] bits;
    mask = 0;
    err  = 0;
    for (int k = 0; k < 4; k++) begin
      bits = fl[3*k +: 3];
      if (bits != 3'b000) mask = mask | (1 << k);
      err = err + $countones(bits);
    end
    if (err > emax) err = emax;
  endtask

  task automatic check_reset_state(input int u, input string name);
    check({name, ".drvA"}, int'(drv_a[u]), 0);
    check({name, ".drvB"}, int'(drv_b[u]), 0);
    check({name, ".busy"}, int'(busy[u]), 0);
    check({name, ".done"}, int'(done[u]), 0);
    check({name, ".pass"}, int'(pass[u]), 0);
    check({name, ".mask"}, int'(fail_mask[u]), 0);
    check({name, ".err"},  err_of(u), 0);
  endtask

  // One full sweep: start pulse, cycle-by-cycle drive/busy checks, then
  // the DONE results and their hold.
  task automatic run_sweep(input int u, input logic [11:0] fl, input bit glitch_en,
                           input bit busy_start, input int exp_mask, input int exp_err,
                           input string name);
    int s;
    int n;
    s = settle_of(u);
    n = 4 * (s + 1);
    flip[u] = fl;
    @(negedge clk);
    start[u] = 1'b1;
    @(posedge clk);
    #1;
    start[u] = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check({name, ".drv"},  int'({drv_a[u], drv_b[u]}), c / (s + 1));
      check({name, ".busy"}, int'(busy[u]), 1);
      check({name, ".done"}, int'(done[u]), 0);
      if (c == 0) begin
        check({name, ".clr_mask"}, int'(fail_mask[u]), 0);
        check({name, ".clr_err"},  err_of(u), 0);
      end
      if (glitch_en && c == 0) glitch[u] = 1'b1;
      if (c == 1) glitch[u] = 1'b0;
      if (busy_start && c == 2) start[u] = 1'b1;
      if (c == 3) start[u] = 1'b0;
    end
    @(negedge clk);
    check({name, ".done_at"}, int'(done[u]), 1);
    check({name, ".busy_end"}, int'(busy[u]), 0);
    check({name, ".pass"}, int'(pass[u]), (exp_mask == 0) ? 1 : 0);
    check({name, ".mask"}, int'(fail_mask[u]), exp_mask);
    check({name, ".err"},  err_of(u), exp_err);
    check({name, ".drv_hold"}, int'({drv_a[u], drv_b[u]}), 3);
    repeat (3) @(negedge clk);
    check({name, ".done_hold"}, int'(done[u]), 1);
    check({name, ".mask_hold"}, int'(fail_mask[u]), exp_mask);
    check({name, ".err_hold"},  err_of(u), exp_err);
  endtask

  typedef struct {
    int          u;
    logic [11:0] fl;
    bit          glitch_en;
    bit          busy_start;
    int          exp_mask;
    int          exp_err;
    string       name;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int m;
    int e;
    int s;
    int u;
    logic [11:0] fl;

    // Directed cases; expected results written out by hand.
    tbl[0] = '{0, 12'h000, 1'b0, 1'b0, 4'b0000, 0,  "clean_s1"};
    tbl[1] = '{0, 12'h009, 1'b0, 1'b0, 4'b0011, 2,  "not_tied0"};   // NOT wrong only when A=0
    tbl[2] = '{1, 12'hFFF, 1'b0, 1'b0, 4'b1111, 3,  "all_inv_sat"};
    tbl[3] = '{1, 12'h000, 1'b1, 1'b0, 4'b0000, 0,  "glitch_s3"};
    tbl[4] = '{0, 12'hFFF, 1'b0, 1'b1, 4'b1111, 12, "all_inv_e4"};
    tbl[5] = '{0, 12'h800, 1'b0, 1'b1, 4'b1000, 1,  "and_v3"};

    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i]  = 1'b0;
      flip[i]   = 12'h000;
      glitch[i] = 1'b0;
    end
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state(0, "rst0");
    check_reset_state(1, "rst1");
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_no_start.busy", int'(busy[0]), 0);

    for (int i = 0; i < 6; i++) begin
      run_sweep(tbl[i].u, tbl[i].fl, tbl[i].glitch_en, tbl[i].busy_start,
                tbl[i].exp_mask, tbl[i].exp_err, tbl[i].name);
    end

    // Reset during the vector-2 drive phase of unit 0.
    s = settle_of(0);
    flip[0] = 12'h924;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    for (int c = 0; c <= 2 * (s + 1); c++) @(negedge clk);
    check("pre_rst.drv", int'({drv_a[0], drv_b[0]}), 2);
    reset_n = 1'b0;
    #1;
    check_reset_state(0, "mid_rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_state(0, "post_rst");
    run_sweep(0, 12'h000, 1'b0, 1'b0, 0, 0, "after_rst");

    // Randomized flip tables against the reference model.
    for (int i = 0; i < 16; i++) begin
      u  = int'($urandom_range(0, 1));
      fl = 12'($urandom & $urandom & $urandom);
      model(fl, errmax_of(u), m, e);
      run_sweep(u, fl, 1'b0, ($urandom_range(0, 3) == 0), m, e, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
